// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder
//   Receive-side monitor for a 4-digit multiplexed common-anode FND display.
//   Watches the scanned digit-select and segment lines, waits until each
//   (com, data) pair has been stable long enough, decodes the segment pattern
//   back to a hex nibble and stores it in the slot chosen by the com line.
//   When all four slots have been captured the frame is snapshotted, checked
//   for decimal digits and converted from BCD to binary over four cycles.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   fnd_com[3:0] in   active-low one-hot digit select (1110 = ones ... 0111 = thousands)
//   fnd_data[7:0]in   active-low segment pattern, bit7 = dp
//   digits[15:0] out  last completed frame {thousands, hundreds, tens, ones}
//   value[13:0]  out  binary value of the last decimal frame
//   value_valid  out  one-cycle pulse when value updates
//   frame_error  out  one-cycle pulse when a completed frame holds a non-decimal digit
//   seg_error    out  one-cycle pulse on a stable but illegal com/data pair
//   timeout      out  level, no frame finished within FRAME_TIMEOUT cycles
//
// Output protocol: value_valid is a qualifier pulse only, there is no ready;
// value is stable from the value_valid cycle until the next value_valid.
module fnd_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 400_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd_data,
    output logic [15:0] digits,
    output logic [13:0] value,
    output logic        value_valid,
    output logic        frame_error,
    output logic        seg_error,
    output logic        timeout
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] S_ARM = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX = TW'(FRAME_TIMEOUT - 1);

    typedef enum logic [1:0] {COLLECT, CHECK, CONV, DONE} state_t;

    // Inverse of the driver segment table; bit4 flags a legal pattern.
    function automatic logic [4:0] seg_decode(input logic [7:0] seg);
        case (seg)
            8'hc0: seg_decode = 5'h10;
            8'hf9: seg_decode = 5'h11;
            8'ha4: seg_decode = 5'h12;
            8'hb0: seg_decode = 5'h13;
            8'h99: seg_decode = 5'h14;
            8'h92: seg_decode = 5'h15;
            8'h82: seg_decode = 5'h16;
            8'hf8: seg_decode = 5'h17;
            8'h80: seg_decode = 5'h18;
            8'h90: seg_decode = 5'h19;
            8'h88: seg_decode = 5'h1a;
            8'h83: seg_decode = 5'h1b;
            8'hc6: seg_decode = 5'h1c;
            8'ha1: seg_decode = 5'h1d;
            8'h7f: seg_decode = 5'h1e;
            8'hff: seg_decode = 5'h1f;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    logic [3:0]    com_s_q, com_s_d, com_p_q, com_p_d;
    logic [7:0]    data_s_q, data_s_d, data_p_q, data_p_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic [3:0]    mask_q, mask_d;
    logic [15:0]   slot_q, slot_d;
    logic [15:0]   snap_q, snap_d;
    logic [15:0]   digits_q, digits_d;
    logic [13:0]   acc_q, acc_d;
    logic [13:0]   value_q, value_d;
    logic [1:0]    conv_idx_q, conv_idx_d;
    logic          seg_err_q, seg_err_d;
    logic          frame_err_q, frame_err_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    state_t        state_q, state_d;

    logic          same, accept, com_onehot, com_blank, capture, complete, tmo_clr;
    logic [4:0]    dec;
    logic [3:0]    cur_digit;

    always_comb begin
        com_s_d     = fnd_com;
        data_s_d    = fnd_data;
        com_p_d     = com_s_q;
        data_p_d    = data_s_q;
        stab_cnt_d  = stab_cnt_q;
        mask_d      = mask_q;
        slot_d      = slot_q;
        snap_d      = snap_q;
        digits_d    = digits_q;
        acc_d       = acc_q;
        value_d     = value_q;
        conv_idx_d  = conv_idx_q;
        frame_err_d = 1'b0;
        state_d     = state_q;
        complete    = 1'b0;
        cur_digit   = 4'h0;

        // Stability: count repeats of the sampled pair; accept once on reaching
        // STABLE_CYCLES, then saturate so the same pair never re-accepts.
        same = (com_s_q == com_p_q) && (data_s_q == data_p_q);
        if (!same)
            stab_cnt_d = '0;
        else if (stab_cnt_q != S_MAX)
            stab_cnt_d = stab_cnt_q + 1'b1;
        accept = same && (stab_cnt_q == S_ARM);

        dec        = seg_decode(data_s_q);
        com_blank  = (com_s_q == 4'b1111);
        com_onehot = (com_s_q == 4'b1110) || (com_s_q == 4'b1101) ||
                     (com_s_q == 4'b1011) || (com_s_q == 4'b0111);
        seg_err_d  = accept && !com_blank && (!com_onehot || !dec[4]);
        capture    = accept && com_onehot && dec[4];

        if (capture) begin
            case (com_s_q)
                4'b1110: slot_d[3:0]   = dec[3:0];
                4'b1101: slot_d[7:4]   = dec[3:0];
                4'b1011: slot_d[11:8]  = dec[3:0];
                default: slot_d[15:12] = dec[3:0];
            endcase
            // Mask clears on completion even if the converter is busy, so the
            // next frame collects cleanly (a busy-time frame is simply dropped).
            if ((mask_q | ~com_s_q) == 4'b1111) begin
                complete = 1'b1;
                mask_d   = 4'b0000;
            end else begin
                mask_d = mask_q | ~com_s_q;
            end
        end

        case (conv_idx_q)
            2'd0:    cur_digit = snap_q[15:12];
            2'd1:    cur_digit = snap_q[11:8];
            2'd2:    cur_digit = snap_q[7:4];
            default: cur_digit = snap_q[3:0];
        endcase

        case (state_q)
            COLLECT: begin
                if (complete) begin
                    snap_d   = slot_d;
                    digits_d = slot_d;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if ((snap_q[3:0] > 4'd9) || (snap_q[7:4] > 4'd9) ||
                    (snap_q[11:8] > 4'd9) || (snap_q[15:12] > 4'd9)) begin
                    frame_err_d = 1'b1;
                    state_d     = COLLECT;
                end else begin
                    acc_d      = '0;
                    conv_idx_d = 2'd0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                // acc*10 + digit as shift-add; 9999 fits in 14 bits.
                acc_d      = (acc_q << 3) + (acc_q << 1) + {10'd0, cur_digit};
                conv_idx_d = conv_idx_q + 2'd1;
                if (conv_idx_q == 2'd3) begin
                    value_d = acc_d;
                    state_d = DONE;
                end
            end
            default: state_d = COLLECT;
        endcase

        tmo_clr = (state_q == DONE) || frame_err_q;
        if (tmo_clr)
            tmo_cnt_d = '0;
        else if (tmo_cnt_q != T_MAX)
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        else
            tmo_cnt_d = tmo_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            com_s_q     <= 4'hf;
            data_s_q    <= 8'hff;
            com_p_q     <= 4'hf;
            data_p_q    <= 8'hff;
            stab_cnt_q  <= '0;
            mask_q      <= '0;
            slot_q      <= '0;
            snap_q      <= '0;
            digits_q    <= '0;
            acc_q       <= '0;
            value_q     <= '0;
            conv_idx_q  <= '0;
            seg_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tmo_cnt_q   <= '0;
            state_q     <= COLLECT;
        end else begin
            com_s_q     <= com_s_d;
            data_s_q    <= data_s_d;
            com_p_q     <= com_p_d;
            data_p_q    <= data_p_d;
            stab_cnt_q  <= stab_cnt_d;
            mask_q      <= mask_d;
            slot_q      <= slot_d;
            snap_q      <= snap_d;
            digits_q    <= digits_d;
            acc_q       <= acc_d;
            value_q     <= value_d;
            conv_idx_q  <= conv_idx_d;
            seg_err_q   <= seg_err_d;
            frame_err_q <= frame_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
            state_q     <= state_d;
        end
    end

    assign digits      = digits_q;
    assign value       = value_q;
    assign value_valid = (state_q == DONE);
    assign frame_error = frame_err_q;
    assign seg_error   = seg_err_q;
    // Drops in the same cycle as the clearing event.
    assign timeout     = (tmo_cnt_q == T_MAX) && !tmo_clr;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: STABLE_CYCLES=4, FRAME_TIMEOUT=100.
module tb_fnd_scan_decoder;

    localparam int STABLE = 4;
    localparam int FT     = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  fnd_com  = 4'hf;
    logic [7:0]  fnd_data = 8'hff;
    logic [15:0] digits;
    logic [13:0] value;
    logic        value_valid, frame_error, seg_error, timeout;

    fnd_scan_decoder #(.STABLE_CYCLES(STABLE), .FRAME_TIMEOUT(FT)) dut (
        .clk(clk), .rst(rst), .fnd_com(fnd_com), .fnd_data(fnd_data),
        .digits(digits), .value(value), .value_valid(value_valid),
        .frame_error(frame_error), .seg_error(seg_error), .timeout(timeout)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int vv_cnt = 0, fe_cnt = 0, se_cnt = 0;
    logic [13:0] exp_q[$];
    logic [13:0] exp_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (value_valid) begin
                vv_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_value_valid: value=%0d, expected no pulse", value);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("value_at_valid", value, exp_v);
                end
            end
            if (seg_error)   se_cnt++;
            if (frame_error) fe_cnt++;
        end
    end

    // ---------------- driver ----------------
    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: seg_of = 8'hc0; 4'h1: seg_of = 8'hf9; 4'h2: seg_of = 8'ha4;
            4'h3: seg_of = 8'hb0; 4'h4: seg_of = 8'h99; 4'h5: seg_of = 8'h92;
            4'h6: seg_of = 8'h82; 4'h7: seg_of = 8'hf8; 4'h8: seg_of = 8'h80;
            4'h9: seg_of = 8'h90; 4'ha: seg_of = 8'h88; 4'hb: seg_of = 8'h83;
            4'hc: seg_of = 8'hc6; 4'hd: seg_of = 8'ha1; 4'he: seg_of = 8'h7f;
            default: seg_of = 8'hff;
        endcase
    endfunction

    task automatic drive_pair(input logic [3:0] c, input logic [7:0] d, input int hold);
        fnd_com  = c;
        fnd_data = d;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic scan_frame(input logic [15:0] nib);
        drive_pair(4'b1110, seg_of(nib[3:0]),   10);
        drive_pair(4'b1101, seg_of(nib[7:4]),   10);
        drive_pair(4'b1011, seg_of(nib[11:8]),  10);
        drive_pair(4'b0111, seg_of(nib[15:12]), 10);
        drive_pair(4'b1111, 8'hff, 12);
    endtask

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [15:0] nib;
        logic        ferr;
        logic [13:0] val;   // value expected after the frame
    } vec_t;
    vec_t vecs[8];

    int vv0, fe0, se0, lat;
    logic [15:0] last_digits;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{nib: 16'h9999, ferr: 1'b0, val: 14'h270f};
        vecs[1] = '{nib: 16'h0000, ferr: 1'b0, val: 14'd0};
        vecs[2] = '{nib: 16'h7a05, ferr: 1'b1, val: 14'd0};
        vecs[3] = '{nib: 16'h4096, ferr: 1'b0, val: 14'd4096};
        vecs[4] = '{nib: 16'h8051, ferr: 1'b0, val: 14'd8051};
        vecs[5] = '{nib: 16'h0c12, ferr: 1'b1, val: 14'd8051};
        vecs[6] = '{nib: 16'h0007, ferr: 1'b0, val: 14'd7};
        vecs[7] = '{nib: 16'hbde3, ferr: 1'b1, val: 14'd7};

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_digits", digits, 16'h0);
        check("rst_value", value, 14'h0);
        check("rst_value_valid", value_valid, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        check("rst_seg_error", seg_error, 1'b0);
        check("rst_timeout", timeout, 1'b0);

        // timeout with idle inputs: rises at cycle FT-1 after reset and holds
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk);
            #1;
            if (k == FT - 2) check("timeout_before", timeout, 1'b0);
            if (k == FT - 1) check("timeout_rise", timeout, 1'b1);
            if (k == 150)    check("timeout_hold", timeout, 1'b1);
        end

        // 1234 with latency from the thousands pair being driven:
        // 1 sample stage + STABLE repeats to accept, then 6 cycles to value_valid
        vv0 = vv_cnt;
        exp_q.push_back(14'd1234);
        drive_pair(4'b1110, seg_of(4'h4), 10);
        drive_pair(4'b1101, seg_of(4'h3), 10);
        drive_pair(4'b1011, seg_of(4'h2), 10);
        fnd_com  = 4'b0111;
        fnd_data = seg_of(4'h1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (value_valid && lat == 0) begin
                lat = k;
                check("timeout_clear_on_valid", timeout, 1'b0);
            end
        end
        check("latency_1234", lat, STABLE + 7);
        drive_pair(4'b1111, 8'hff, 5);
        check("digits_1234", digits, 16'h1234);
        check("value_1234", value, 14'd1234);
        check("valid_count_1234", vv_cnt - vv0, 1);
        check("timeout_after_good", timeout, 1'b0);

        // table-driven frames
        for (int i = 0; i < 8; i++) begin
            vv0 = vv_cnt;
            fe0 = fe_cnt;
            if (!vecs[i].ferr) exp_q.push_back(vecs[i].val);
            scan_frame(vecs[i].nib);
            check("vec_digits", digits, vecs[i].nib);
            check("vec_frame_error", fe_cnt - fe0, vecs[i].ferr ? 1 : 0);
            check("vec_valid_count", vv_cnt - vv0, vecs[i].ferr ? 0 : 1);
            check("vec_value", value, vecs[i].val);
        end
        last_digits = 16'hbde3;

        // tens pair held only 3 cycles: not captured, frame incomplete
        vv0 = vv_cnt;
        drive_pair(4'b1110, seg_of(4'h1), 10);
        drive_pair(4'b1101, seg_of(4'h2), 3);
        drive_pair(4'b1011, seg_of(4'h3), 10);
        drive_pair(4'b0111, seg_of(4'h4), 10);
        drive_pair(4'b1111, 8'hff, 12);
        check("short_hold_no_valid", vv_cnt - vv0, 0);
        check("short_hold_digits", digits, last_digits);
        // a proper tens capture now completes the frame out of order
        exp_q.push_back(14'd4321);
        drive_pair(4'b1101, seg_of(4'h2), 10);
        drive_pair(4'b1111, 8'hff, 12);
        check("late_tens_digits", digits, 16'h4321);
        check("late_tens_value", value, 14'd4321);
        check("late_tens_valid", vv_cnt - vv0, 1);
        last_digits = 16'h4321;

        // illegal pairs in the middle of a frame
        se0 = se_cnt;
        exp_q.push_back(14'd2068);
        drive_pair(4'b1110, seg_of(4'h8), 10);
        drive_pair(4'b1101, seg_of(4'h6), 10);
        drive_pair(4'b1011, seg_of(4'h0), 10);
        drive_pair(4'b1101, 8'h00, 10);
        check("seg_err_bad_data", se_cnt - se0, 1);
        check("seg_err_digits_kept", digits, last_digits);
        drive_pair(4'b1100, 8'hc0, 10);
        check("seg_err_bad_com", se_cnt - se0, 2);
        drive_pair(4'b0111, seg_of(4'h2), 10);
        drive_pair(4'b1111, 8'hff, 12);
        check("seg_frame_digits", digits, 16'h2068);
        check("seg_frame_value", value, 14'd2068);

        // reset while converting: no pulse for the aborted frame
        vv0 = vv_cnt;
        drive_pair(4'b1110, seg_of(4'h3), 10);
        drive_pair(4'b1101, seg_of(4'h2), 10);
        drive_pair(4'b1011, seg_of(4'h1), 10);
        drive_pair(4'b0111, seg_of(4'h9), 8);
        rst      = 1'b1;
        fnd_com  = 4'hf;
        fnd_data = 8'hff;
        repeat (2) @(posedge clk);
        #1;
        check("midconv_value", value, 14'd0);
        check("midconv_digits", digits, 16'h0);
        check("midconv_timeout", timeout, 1'b0);
        rst = 1'b0;
        drive_pair(4'b1111, 8'hff, 20);
        check("midconv_no_valid", vv_cnt - vv0, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
